// File: rtl/gmii_pkt_gen.sv
// rtl/gmii_pkt_gen.sv - GMII Ethernet frame generator with preamble, padding, CRC-32 FCS and IFG control
module gmii_pkt_gen #(
    parameter int MAX_PAYLOAD = 1500,
    parameter int IFG_MIN     = 12,
    parameter int PAD_EN      = 1,
    parameter int CNT_W       = 16
) (
    input  logic             gmii_gtxc,
    input  logic             RESETn,
    input  logic             start,
    input  logic             stop,
    input  logic [47:0]      dst_mac,
    input  logic [47:0]      src_mac,
    input  logic [15:0]      eth_type,
    input  logic [15:0]      bnum_payload,
    input  logic [1:0]       pattern,
    input  logic [7:0]       fill,
    input  logic             preamble,
    input  logic             crc,
    input  logic [7:0]       ifg,
    input  logic [CNT_W-1:0] num_pkts,
    output logic [7:0]       gmii_txd,
    output logic             gmii_txen,
    output logic             gmii_txer,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] pkt_cnt
);

    localparam logic [15:0] MAX_N     = 16'(MAX_PAYLOAD);
    localparam logic [15:0] IFG_FLOOR = 16'(IFG_MIN);
    localparam logic [15:0] MIN_PAY   = 16'd46;

    typedef enum logic [2:0] {IDLE, PRE, HDR, PAY, PAD, FCS, GAP} state_t;

    state_t            state, nxt_state;
    state_t            after_hdr, after_pay, after_pad;
    logic [15:0]       cnt, nxt_cnt;
    logic [111:0]      hdr_q, hdr_src, hdr_sh;
    logic [15:0]       pay_len_q, pad_len_q, gap_len_q;
    logic [15:0]       req_len, req_pad, req_gap;
    logic [1:0]        pat_q;
    logic [7:0]        fill_q, seed;
    logic              pre_q, fcs_en_q;
    logic [CNT_W-1:0]  num_q, pkt_inc;
    logic              stop_flag, finish;
    logic [31:0]       crc_q, crc_cur, fcs_word;
    logic [7:0]        lfsr_q, nxt_lfsr;
    logic              cov_q, nxt_cov;
    logic [7:0]        nxt_txd;
    logic              nxt_txen;

    function automatic logic [31:0] crc_byte(input logic [31:0] c_in, input logic [7:0] d);
        logic [31:0] c;
        c = c_in ^ {24'd0, d};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        return c;
    endfunction

    // Fibonacci LFSR, taps 8,6,5,4
    function automatic logic [7:0] lfsr_step(input logic [7:0] s);
        return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
    endfunction

    assign gmii_txer = 1'b0;

    assign req_len = (bnum_payload > MAX_N) ? MAX_N : bnum_payload;
    assign req_pad = ((PAD_EN != 0) && (req_len < MIN_PAY)) ? (MIN_PAY - req_len) : 16'd0;
    assign req_gap = ({8'd0, ifg} > IFG_FLOOR) ? {8'd0, ifg} : IFG_FLOOR;

    assign after_pad = fcs_en_q ? FCS : GAP;
    assign after_pay = (pad_len_q != 16'd0) ? PAD : after_pad;
    assign after_hdr = (pay_len_q != 16'd0) ? PAY : after_pay;

    assign pkt_inc = pkt_cnt + CNT_W'(1);
    assign finish  = stop_flag || stop || ((num_q != '0) && (pkt_inc == num_q));
    assign seed    = (fill_q == 8'h00) ? 8'h01 : fill_q;

    // The byte on gmii_txd is absorbed one cycle after it is driven
    assign crc_cur  = cov_q ? crc_byte(crc_q, gmii_txd) : crc_q;
    assign fcs_word = ~crc_cur;

    // First header byte leaves on the start cycle, before the latch holds it
    assign hdr_src = (state == IDLE) ? {dst_mac, src_mac, eth_type} : hdr_q;
    assign hdr_sh  = hdr_src << {nxt_cnt[3:0], 3'b000};

    always_comb begin
        nxt_state = state;
        nxt_cnt   = cnt + 16'd1;
        case (state)
            IDLE: if (start) nxt_state = preamble ? PRE : HDR;
            PRE:  if (cnt == 16'd7)  nxt_state = HDR;
            HDR:  if (cnt == 16'd13) nxt_state = after_hdr;
            PAY:  if (cnt == pay_len_q - 16'd1) nxt_state = after_pay;
            PAD:  if (cnt == pad_len_q - 16'd1) nxt_state = after_pad;
            FCS:  if (cnt == 16'd3)  nxt_state = GAP;
            GAP: begin
                if (cnt == gap_len_q - 16'd1) begin
                    if (finish)     nxt_state = IDLE;
                    else if (pre_q) nxt_state = PRE;
                    else            nxt_state = HDR;
                end
            end
            default: nxt_state = IDLE;
        endcase
        if ((nxt_state != state) || (state == IDLE)) nxt_cnt = 16'd0;
    end

    // Output byte for the state/index being entered on this edge
    always_comb begin
        nxt_txd  = 8'h00;
        nxt_txen = 1'b0;
        nxt_cov  = 1'b0;
        nxt_lfsr = lfsr_q;
        case (nxt_state)
            PRE: begin
                nxt_txen = 1'b1;
                nxt_txd  = (nxt_cnt == 16'd7) ? 8'hD5 : 8'h55;
            end
            HDR: begin
                nxt_txen = 1'b1;
                nxt_cov  = 1'b1;
                nxt_txd  = hdr_sh[111:104];
            end
            PAY: begin
                nxt_txen = 1'b1;
                nxt_cov  = 1'b1;
                case (pat_q)
                    2'd1: nxt_txd = fill_q;
                    2'd2: begin
                        nxt_txd  = (nxt_cnt == 16'd0) ? seed : lfsr_step(lfsr_q);
                        nxt_lfsr = nxt_txd;
                    end
                    default: nxt_txd = nxt_cnt[7:0] + 8'd1;
                endcase
            end
            PAD: begin
                nxt_txen = 1'b1;
                nxt_cov  = 1'b1;
            end
            FCS: begin
                nxt_txen = 1'b1;
                case (nxt_cnt[1:0])
                    2'd0:    nxt_txd = fcs_word[7:0];
                    2'd1:    nxt_txd = fcs_word[15:8];
                    2'd2:    nxt_txd = fcs_word[23:16];
                    default: nxt_txd = fcs_word[31:24];
                endcase
            end
            default: ;
        endcase
    end

    always_ff @(posedge gmii_gtxc or negedge RESETn) begin
        if (!RESETn) begin
            state     <= IDLE;
            cnt       <= 16'd0;
            gmii_txd  <= 8'h00;
            gmii_txen <= 1'b0;
            cov_q     <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pkt_cnt   <= '0;
            stop_flag <= 1'b0;
            crc_q     <= 32'hFFFFFFFF;
            lfsr_q    <= 8'h01;
            hdr_q     <= '0;
            pay_len_q <= 16'd0;
            pad_len_q <= 16'd0;
            gap_len_q <= IFG_FLOOR;
            pat_q     <= 2'd0;
            fill_q    <= 8'h00;
            pre_q     <= 1'b0;
            fcs_en_q  <= 1'b0;
            num_q     <= '0;
        end else begin
            state     <= nxt_state;
            cnt       <= nxt_cnt;
            gmii_txd  <= nxt_txd;
            gmii_txen <= nxt_txen;
            cov_q     <= nxt_cov;
            lfsr_q    <= nxt_lfsr;
            crc_q     <= ((state == IDLE) || (state == GAP)) ? 32'hFFFFFFFF : crc_cur;
            busy      <= (nxt_state != IDLE);
            done      <= (state == GAP) && (nxt_state == IDLE);
            if (state == IDLE) begin
                if (start) begin
                    hdr_q     <= {dst_mac, src_mac, eth_type};
                    pay_len_q <= req_len;
                    pad_len_q <= req_pad;
                    gap_len_q <= req_gap;
                    pat_q     <= pattern;
                    fill_q    <= fill;
                    pre_q     <= preamble;
                    fcs_en_q  <= crc;
                    num_q     <= num_pkts;
                    pkt_cnt   <= '0;
                    stop_flag <= stop;
                end else begin
                    stop_flag <= 1'b0;
                end
            end else begin
                stop_flag <= stop_flag | stop;
                if ((state == GAP) && (nxt_state != GAP)) pkt_cnt <= pkt_inc;
            end
        end
    end

endmodule

// File: tb/tb_gmii_pkt_gen.sv
// tb/tb_gmii_pkt_gen.sv - directed self-checking bench for gmii_pkt_gen
module tb_gmii_pkt_gen;

    logic        gmii_gtxc = 1'b0;
    logic        RESETn = 1'b0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic [47:0] dst_mac = 48'hA1B2C3D4E5F6;
    logic [47:0] src_mac = 48'h665544332211;
    logic [15:0] eth_type = 16'h0800;
    logic [15:0] bnum_payload = 16'd0;
    logic [1:0]  pattern = 2'd0;
    logic [7:0]  fill = 8'h00;
    logic        preamble = 1'b1;
    logic        crc = 1'b1;
    logic [7:0]  ifg = 8'd12;
    logic [15:0] num_pkts = 16'd1;
    logic [7:0]  gmii_txd;
    logic        gmii_txen;
    logic        gmii_txer;
    logic        busy;
    logic        done;
    logic [15:0] pkt_cnt;

    gmii_pkt_gen dut (
        .gmii_gtxc(gmii_gtxc), .RESETn(RESETn), .start(start), .stop(stop),
        .dst_mac(dst_mac), .src_mac(src_mac), .eth_type(eth_type),
        .bnum_payload(bnum_payload), .pattern(pattern), .fill(fill),
        .preamble(preamble), .crc(crc), .ifg(ifg), .num_pkts(num_pkts),
        .gmii_txd(gmii_txd), .gmii_txen(gmii_txen), .gmii_txer(gmii_txer),
        .busy(busy), .done(done), .pkt_cnt(pkt_cnt)
    );

    always #4 gmii_gtxc = ~gmii_gtxc;

    logic [7:0] cur[$];
    logic [7:0] frm[$];
    int         lens[$];
    int         gaps[$];
    int         gap_run = 0;
    logic       prev_en = 1'b0;
    int         done_cnt = 0;
    int         bad_idle = 0;
    int         txer_cnt = 0;

    // Frame capture on the falling edge, away from the launching edge
    always @(negedge gmii_gtxc) begin
        if (gmii_txen) begin
            if (!prev_en && lens.size() > 0) gaps.push_back(gap_run);
            cur.push_back(gmii_txd);
        end else begin
            if (prev_en) begin
                frm = cur;
                lens.push_back(cur.size());
                cur.delete();
                gap_run = 0;
            end
            gap_run++;
            if (gmii_txd !== 8'h00) bad_idle++;
        end
        if (gmii_txer !== 1'b0) txer_cnt++;
        if (done === 1'b1) done_cnt++;
        prev_en = gmii_txen;
    end

    int tests = 0;
    int fails = 0;
    int lb, gb, db, k;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge gmii_gtxc);
        #2;
    endtask

    task automatic config_run(input logic [15:0] pay, input logic [1:0] pat, input logic [7:0] fl,
                              input logic pre, input logic c, input logic [7:0] g, input logic [15:0] np);
        bnum_payload = pay;
        pattern      = pat;
        fill         = fl;
        preamble     = pre;
        crc          = c;
        ifg          = g;
        num_pkts     = np;
    endtask

    task automatic go(input logic with_stop);
        start = 1'b1;
        stop  = with_stop;
        step();
        start = 1'b0;
        stop  = 1'b0;
    endtask

    task automatic wait_done(input int target, input int budget, input string tag);
        int n = 0;
        while (done_cnt < target && n < budget) begin
            step();
            n++;
        end
        check(tag, 32'(done_cnt >= target), 32'd1);
    endtask

    function automatic logic [31:0] residue(input int a, input int b);
        logic [31:0] c = 32'hFFFFFFFF;
        for (int i = a; i <= b; i++) begin
            c = c ^ {24'd0, frm[i]};
            for (int j = 0; j < 8; j++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        return c;
    endfunction

    initial begin
        logic [7:0] acc;

        repeat (3) step();
        check("rst_txen", 32'(gmii_txen), 32'd0);
        check("rst_txd", 32'(gmii_txd), 32'h00);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_pkt_cnt", 32'(pkt_cnt), 32'd0);
        check("rst_txer", 32'(gmii_txer), 32'd0);
        RESETn = 1'b1;
        repeat (2) step();

        // payload 1, padded single frame with preamble and FCS
        config_run(16'd1, 2'd0, 8'h00, 1'b1, 1'b1, 8'd12, 16'd1);
        lb = lens.size(); db = done_cnt;
        go(1'b0);
        check("a_lat_txen", 32'(gmii_txen), 32'd1);
        check("a_lat_txd", 32'(gmii_txd), 32'h55);
        check("a_busy", 32'(busy), 32'd1);
        wait_done(db + 1, 400, "a_done_seen");
        repeat (5) step();
        check("a_frames", 32'(lens.size() - lb), 32'd1);
        check("a_len", 32'(lens[lens.size() - 1]), 32'd72);
        check("a_sfd", 32'(frm[7]), 32'hD5);
        check("a_dst0", 32'(frm[8]), 32'hA1);
        check("a_src5", 32'(frm[19]), 32'h11);
        check("a_type", 32'({frm[20], frm[21]}), 32'h0800);
        check("a_pay0", 32'(frm[22]), 32'h01);
        acc = 8'h00;
        for (int i = 23; i <= 67; i++) acc = acc | frm[i];
        check("a_pad_zero", 32'(acc), 32'h00);
        check("a_residue", residue(8, 71), 32'hDEBB20E3);
        check("a_pkt_cnt", 32'(pkt_cnt), 32'd1);
        check("a_busy_end", 32'(busy), 32'd0);
        check("a_done_once", 32'(done_cnt - db), 32'd1);

        // three frames, requested gap below floor
        config_run(16'd100, 2'd0, 8'h00, 1'b1, 1'b1, 8'd5, 16'd3);
        lb = lens.size(); gb = gaps.size(); db = done_cnt;
        go(1'b0);
        wait_done(db + 1, 1000, "b_done_seen");
        repeat (3) step();
        check("b_frames", 32'(lens.size() - lb), 32'd3);
        check("b_len0", 32'(lens[lb]), 32'd126);
        check("b_len2", 32'(lens[lb + 2]), 32'd126);
        check("b_gaps", 32'(gaps.size() - gb), 32'd3);
        check("b_gap1", 32'(gaps[gb + 1]), 32'd12);
        check("b_gap2", 32'(gaps[gb + 2]), 32'd12);
        check("b_pay_last", 32'(frm[121]), 32'h64);
        check("b_residue", residue(8, 125), 32'hDEBB20E3);
        check("b_pkt_cnt", 32'(pkt_cnt), 32'd3);

        // oversized payload clamps to MAX_PAYLOAD
        config_run(16'd2000, 2'd0, 8'h00, 1'b1, 1'b1, 8'd12, 16'd1);
        db = done_cnt;
        go(1'b0);
        wait_done(db + 1, 3000, "c_done_seen");
        repeat (3) step();
        check("c_len", 32'(lens[lens.size() - 1]), 32'd1526);
        check("c_pay_last", 32'(frm[1521]), 32'hDC);
        check("c_residue", residue(8, 1525), 32'hDEBB20E3);

        // free-running, stop during second frame; constant pattern
        config_run(16'd20, 2'd1, 8'h5A, 1'b1, 1'b1, 8'd12, 16'd0);
        lb = lens.size(); db = done_cnt;
        go(1'b0);
        k = 0;
        while (!((lens.size() - lb >= 1) && gmii_txen) && k < 500) begin
            step();
            k++;
        end
        check("d_second_started", 32'(k < 500), 32'd1);
        repeat (10) step();
        stop = 1'b1;
        step();
        stop = 1'b0;
        wait_done(db + 1, 500, "d_done_seen");
        repeat (60) step();
        check("d_frames", 32'(lens.size() - lb), 32'd2);
        check("d_len", 32'(lens[lens.size() - 1]), 32'd72);
        check("d_fill_first", 32'(frm[22]), 32'h5A);
        check("d_fill_last", 32'(frm[41]), 32'h5A);
        check("d_pad", 32'(frm[42]), 32'h00);
        check("d_residue", residue(8, 71), 32'hDEBB20E3);
        check("d_pkt_cnt", 32'(pkt_cnt), 32'd2);
        check("d_done_once", 32'(done_cnt - db), 32'd1);

        // stop together with start: one frame only
        config_run(16'd1, 2'd0, 8'h00, 1'b0, 1'b1, 8'd12, 16'd0);
        lb = lens.size(); db = done_cnt;
        go(1'b1);
        wait_done(db + 1, 400, "g_done_seen");
        repeat (30) step();
        check("g_frames", 32'(lens.size() - lb), 32'd1);
        check("g_len", 32'(lens[lens.size() - 1]), 32'd64);
        check("g_pkt_cnt", 32'(pkt_cnt), 32'd1);

        // PRBS with zero seed, no preamble, no FCS
        config_run(16'd4, 2'd2, 8'h00, 1'b0, 1'b0, 8'd12, 16'd1);
        db = done_cnt;
        go(1'b0);
        check("e_lat_txd", 32'(gmii_txd), 32'hA1);
        wait_done(db + 1, 300, "e_done_seen");
        repeat (3) step();
        check("e_len", 32'(lens[lens.size() - 1]), 32'd60);
        check("e_prbs", 32'({frm[14], frm[15], frm[16], frm[17]}), 32'h01020408);
        check("e_pad", 32'(frm[18]), 32'h00);

        // PRBS seeded 0x80 exercises the feedback taps
        config_run(16'd4, 2'd2, 8'h80, 1'b0, 1'b0, 8'd12, 16'd1);
        db = done_cnt;
        go(1'b0);
        wait_done(db + 1, 300, "e2_done_seen");
        repeat (3) step();
        check("e2_prbs", 32'({frm[14], frm[15], frm[16], frm[17]}), 32'h80010204);

        // reset asserted mid-frame
        config_run(16'd100, 2'd0, 8'h00, 1'b1, 1'b1, 8'd12, 16'd1);
        go(1'b0);
        k = 0;
        while (cur.size() < 30 && k < 200) begin
            step();
            k++;
        end
        check("f_reached_byte30", 32'(cur.size()), 32'd30);
        RESETn = 1'b0;
        #1;
        check("f_rst_txen", 32'(gmii_txen), 32'd0);
        check("f_rst_txd", 32'(gmii_txd), 32'h00);
        check("f_rst_busy", 32'(busy), 32'd0);
        step();
        RESETn = 1'b1;
        step();
        lb = lens.size();
        repeat (40) step();
        check("f_quiet_frames", 32'(lens.size() - lb), 32'd0);
        check("f_quiet_txen", 32'(gmii_txen), 32'd0);
        check("f_quiet_busy", 32'(busy), 32'd0);

        // second start and config change while busy are ignored
        config_run(16'd4, 2'd0, 8'h00, 1'b0, 1'b1, 8'd12, 16'd1);
        lb = lens.size(); db = done_cnt;
        go(1'b0);
        repeat (5) step();
        config_run(16'd100, 2'd0, 8'h00, 1'b1, 1'b1, 8'd12, 16'd3);
        go(1'b0);
        wait_done(db + 1, 400, "h_done_seen");
        repeat (40) step();
        check("h_frames", 32'(lens.size() - lb), 32'd1);
        check("h_len", 32'(lens[lens.size() - 1]), 32'd64);
        check("h_residue", residue(0, 63), 32'hDEBB20E3);
        check("h_pkt_cnt", 32'(pkt_cnt), 32'd1);
        check("h_done_once", 32'(done_cnt - db), 32'd1);

        check("idle_txd_zero", 32'(bad_idle), 32'd0);
        check("txer_low", 32'(txer_cnt), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/gmii_pkt_gen.md
GMII_PKT_GEN -- requirements
Module: gmii_pkt_gen

Interface
REQ-001 Parameter MAX_PAYLOAD, default 1500: largest payload byte count accepted; larger requests clamp to it.
REQ-002 Parameter IFG_MIN, default 12: floor applied to the requested inter-frame gap, in bytes.
REQ-003 Parameter PAD_EN, default 1: when 1, short payloads are zero-padded to 46 bytes.
REQ-004 Parameter CNT_W, default 16: width of the packet-count ports.
REQ-005 The block has one clock, gmii_gtxc; RESETn is asynchronous and active-low.
REQ-006 Ports (name, direction, width, meaning):
- gmii_gtxc in 1 -- 125 MHz GMII TX clock.
- RESETn in 1 -- asynchronous active-low reset.
- start in 1 -- one-cycle pulse that launches a run.
- stop in 1 -- pulse that ends a run after the current frame.
- dst_mac in 48 -- destination MAC; bits [47:40] are sent first.
- src_mac in 48 -- source MAC; bits [47:40] are sent first.
- eth_type in 16 -- EtherType/length field; bits [15:8] are sent first.
- bnum_payload in 16 -- payload byte count.
- pattern in 2 -- payload pattern select: 0 increment, 1 constant, 2 PRBS.
- fill in 8 -- constant byte, and PRBS seed.
- preamble in 1 -- when 1, prepend 7x0x55 + 0xD5.
- crc in 1 -- when 1, append the 4-byte FCS.
- ifg in 8 -- requested inter-frame gap, in bytes.
- num_pkts in CNT_W -- frames per run; 0 means run until stop.
- gmii_txd out 8 -- TX data.
- gmii_txen out 1 -- TX enable.
- gmii_txer out 1 -- TX error.
- busy out 1 -- high while a run is active.
- done out 1 -- one-cycle pulse at the end of a run.
- pkt_cnt out CNT_W -- frames completed in the current run.

Function
REQ-007 States: IDLE, PRE, HDR, PAY, PAD, FCS, GAP; each state advances one byte per gmii_gtxc cycle.
REQ-008 All configuration inputs are latched on the cycle start is sampled in IDLE; changes during a run have no effect.
REQ-009 In IDLE, start moves to PRE if preamble=1, otherwise to HDR; gmii_txen rises on the next cycle (1-cycle latency).
REQ-010 start while busy=1 is ignored.
REQ-011 PRE sends 8 bytes: 0x55 x7, then 0xD5.
REQ-012 HDR sends 14 bytes: dst_mac, src_mac, eth_type, each MSB byte first.
REQ-013 PAY sends N = min(bnum_payload, MAX_PAYLOAD) bytes.
- N=0 skips PAY.
- Increment pattern: byte k = (k+1) mod 256.
- Constant pattern: every byte = fill.
- PRBS pattern: 8-bit Fibonacci LFSR x^8+x^6+x^5+x^4+1, seeded with fill (0x00 replaced by 0x01), reseeded per frame; the first byte is the seed.
- pattern=3 behaves as pattern 0.
REQ-014 PAD: when PAD_EN=1 and N<46, send 46-N bytes of 0x00; otherwise skip PAD.
REQ-015 FCS (crc=1): IEEE 802.3 CRC-32 over HDR+PAY+PAD.
- Reflected polynomial 0xEDB88320, init 0xFFFFFFFF, final complement.
- Sent least-significant byte first.
REQ-016 With crc=0, FCS is skipped; the CRC engine still runs and its result is discarded.
REQ-017 gmii_txen is high exactly for PRE..FCS bytes; gmii_txd is 0x00 whenever gmii_txen=0.
REQ-018 gmii_txer is always 0.
REQ-019 GAP holds gmii_txen low for max(ifg, IFG_MIN) cycles.
REQ-020 At GAP end, pkt_cnt increments (wraps at 2^CNT_W).
- If pkt_cnt==num_pkts (num_pkts≠0), or stop was seen during the run: go to IDLE, busy=0, done=1 for one cycle.
- Otherwise start the next frame.
REQ-021 stop is latched as a sticky flag; a stop in the same cycle as start is applied after the first frame.
REQ-022 pkt_cnt clears to 0 on each accepted start and holds its value in IDLE.
REQ-023 All byte counters are 16 bits and compare against registered limits; there are no combinational paths from config inputs to outputs.

Reset
REQ-024 While RESETn=0, asynchronously: state=IDLE, gmii_txd=0x00, gmii_txen=0, gmii_txer=0, busy=0, done=0, pkt_cnt=0, stop flag=0, CRC register=0xFFFFFFFF, LFSR=0x01.
REQ-025 Reset asserted mid-frame truncates the frame immediately; after release the block stays in IDLE until a new start.

Verification
REQ-026 Scenario: payload 1, increment, preamble=1, crc=1, num_pkts=1.
- gmii_txen high for 72 cycles.
- Byte 22 = 0x01, bytes 23-67 = 0x00.
- CRC-32 over bytes 8-71 gives residue 0xDEBB20E3.
- done pulses once; pkt_cnt=1.
REQ-027 Scenario: payload 100, num_pkts=3, ifg=5.
- Three 126-byte bursts.
- Gaps of exactly 12 cycles (IFG_MIN floor).
- pkt_cnt=3.
REQ-028 Scenario: bnum_payload=2000.
- Exactly 1500 payload bytes sent.
- Frame is 1526 bytes.
- FCS is valid.
REQ-029 Scenario: num_pkts=0, stop pulsed mid second frame.
- Second frame completes intact.
- No third frame starts.
- pkt_cnt=2; done pulses.
REQ-030 Scenario: pattern=2, fill=0x00, preamble=0, crc=0, payload 4.
- Payload bytes are 0x01 followed by the next three LFSR states.
- gmii_txen high for 60 cycles (PAD_EN=1).
REQ-031 Scenario: RESETn low at byte 30 of a frame.
- gmii_txen=0 in the same cycle.
- After release, no activity until start.
- start while busy is ignored.
